move_select_ctrl: RTL and testbench

- Parametrised successor to the chess-screen move-entry controller.
- Handles cursor navigation, source/destination selection and display overlay on a ROWS x COLS board of PW-bit piece codes.
- Validation is delegated to an external validator over a req/ack handshake with timeout.
- Sits between the debounced key pulses plus stable game board, and the display/network packet path.

---
 rtl/move_select_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_move_select_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_select_ctrl.sv
// ============================================================================
// move_select_ctrl
// ----------------------------------------------------------------------------
// Move-entry controller for a ROWS x COLS board of PW-bit piece codes.
// Drives cursor navigation, source/destination selection and the display
// overlay. Validation is delegated to an external validator over a
// val_req/val_ack handshake, with a timeout that forces a reject.
//
// Optional feature (compile-time macro):
//   CURSOR_WRAP_EN  defined   -> cursor wraps modulo COLS/ROWS
//                   undefined -> cursor saturates at 0 and COLS-1/ROWS-1
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   enable           chess screen active; all state frozen while low
//   my_turn          local player is the current player
//   player           local colour (1 = owns codes <= WHITE_MAX)
//   dir              1: keys step y, 0: keys step x
//   key_dec/key_inc  cursor step pulses (dec: y-1 / x+1, inc: y+1 / x-1)
//   key_enter        select pulse
//   key_cancel       abandon current selection pulse
//   board_in         stable game board, square (x,y) at [(y*COLS+x)*PW +: PW]
//   val_req          validation request (held for the whole VALIDATE phase)
//   val_ack/val_ok   validator result strobe and verdict
//   disp_board       board to render (with the move preview overlay)
//   highlight        one-hot cursor highlight, same square indexing
//   cur_x/cur_y      cursor position
//   src_x/src_y      latched source square
//   sel_piece        latched piece code
//   move_done        one-cycle pulse on an accepted move
//   move_reject      one-cycle pulse on a rejected or timed-out move
//   move_packet      {src_x, src_y, dst_x, dst_y}
//   state            FSM state for debug (0 IDLE, 1 PIECE_SEL, 2 DEST_SEL,
//                    3 VALIDATE)
// ============================================================================
module move_select_ctrl #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int PW          = 4,
    parameter int EMPTY       = 15,
    parameter int WHITE_MAX   = 5,
    parameter int VAL_TIMEOUT = 32,
    localparam int XW  = $clog2(COLS),
    localparam int YW  = $clog2(ROWS),
    localparam int NSQ = ROWS * COLS,
    localparam int PKW = 2 * (XW + YW)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              my_turn,
    input  logic              player,
    input  logic              dir,
    input  logic              key_dec,
    input  logic              key_inc,
    input  logic              key_enter,
    input  logic              key_cancel,
    input  logic [NSQ*PW-1:0] board_in,
    output logic              val_req,
    input  logic              val_ack,
    input  logic              val_ok,
    output logic [NSQ*PW-1:0] disp_board,
    output logic [NSQ-1:0]    highlight,
    output logic [XW-1:0]     cur_x,
    output logic [YW-1:0]     cur_y,
    output logic [XW-1:0]     src_x,
    output logic [YW-1:0]     src_y,
    output logic [PW-1:0]     sel_piece,
    output logic              move_done,
    output logic              move_reject,
    output logic [PKW-1:0]    move_packet,
    output logic [2:0]        state
);

    localparam int CX = COLS / 2 - 1;
    localparam int CY = ROWS / 2 - 1;
    localparam int TW = $clog2(VAL_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PIECE_SEL = 3'd1,
        ST_DEST_SEL  = 3'd2,
        ST_VALIDATE  = 3'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [XW-1:0]       r_cur_x, r_src_x;
    logic [YW-1:0]       r_cur_y, r_src_y;
    logic [PW-1:0]       r_sel;
    logic [TW-1:0]       r_timer;
    logic                r_val_req;
    logic                r_done;
    logic                r_reject;
    logic [PKW-1:0]      r_packet;
    logic [NSQ*PW-1:0]   r_disp;
    logic [NSQ-1:0]      r_hl;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t              w_nxt_state;
    logic [XW-1:0]       w_nxt_cur_x, w_nxt_src_x, w_mv_x;
    logic [YW-1:0]       w_nxt_cur_y, w_nxt_src_y, w_mv_y;
    logic [PW-1:0]       w_nxt_sel;
    logic [TW-1:0]       w_nxt_timer;
    logic                w_nxt_req;
    logic                w_nxt_done;
    logic                w_nxt_reject;
    logic [PKW-1:0]      w_nxt_packet;
    logic [NSQ*PW-1:0]   w_nxt_disp;
    logic [NSQ-1:0]      w_nxt_hl;
    int                  w_cur_sq;
    int                  w_nsq_cur;
    int                  w_nsq_src;
    logic [PW-1:0]       w_cur_piece;
    logic                w_cur_own;
    logic                w_on_src;

    // One cursor step along an axis of length lim; edge handling is the
    // compile-time option.
    function automatic int step_coord(input int v, input int delta, input int lim);
        int n;
        n = v + delta;
`ifdef CURSOR_WRAP_EN
        if (n < 0)
            n = lim - 1;
        else if (n >= lim)
            n = 0;
`else
        if (n < 0)
            n = 0;
        else if (n >= lim)
            n = lim - 1;
`endif
        return n;
    endfunction

    // A piece is ours when it is not EMPTY and its colour matches player.
    function automatic logic is_own(input logic [PW-1:0] p, input logic pl);
        return (int'(p) != EMPTY) && ((int'(p) <= WHITE_MAX) == pl);
    endfunction

    // ------------------------------------------------------------------
    // Square under the (pre-move) cursor and the moved cursor
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path holds its old value and infers a latch.
        w_cur_sq    = int'(r_cur_y) * COLS + int'(r_cur_x);
        w_cur_piece = board_in[w_cur_sq*PW +: PW];
        w_cur_own   = is_own(w_cur_piece, player);
        w_on_src    = (r_cur_x == r_src_x) && (r_cur_y == r_src_y);
        w_mv_x      = r_cur_x;
        w_mv_y      = r_cur_y;
        // key_dec wins over key_inc; the axis mapping is deliberately
        // asymmetric (dec = y-1 or x+1) to match the keypad layout.
        if (key_dec) begin
            if (dir)
                w_mv_y = YW'(step_coord(int'(r_cur_y), -1, ROWS));
            else
                w_mv_x = XW'(step_coord(int'(r_cur_x), 1, COLS));
        end else if (key_inc) begin
            if (dir)
                w_mv_y = YW'(step_coord(int'(r_cur_y), 1, ROWS));
            else
                w_mv_x = XW'(step_coord(int'(r_cur_x), -1, COLS));
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cur_x  = r_cur_x;
        w_nxt_cur_y  = r_cur_y;
        w_nxt_src_x  = r_src_x;
        w_nxt_src_y  = r_src_y;
        w_nxt_sel    = r_sel;
        w_nxt_timer  = r_timer;
        w_nxt_req    = r_val_req;
        w_nxt_done   = 1'b0;
        w_nxt_reject = 1'b0;
        w_nxt_packet = r_packet;

        case (r_state)
            ST_IDLE: begin
                if (my_turn) begin
                    w_nxt_state = ST_PIECE_SEL;
                    w_nxt_cur_x = XW'(CX);
                    w_nxt_cur_y = YW'(CY);
                end
            end

            ST_PIECE_SEL: begin
                if (!my_turn) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    // Enter judges the square the cursor is leaving.
                    if (key_enter && w_cur_own) begin
                        w_nxt_src_x = r_cur_x;
                        w_nxt_src_y = r_cur_y;
                        w_nxt_sel   = w_cur_piece;
                        w_nxt_state = ST_DEST_SEL;
                    end
                    w_nxt_cur_x = w_mv_x;
                    w_nxt_cur_y = w_mv_y;
                end
            end

            ST_DEST_SEL: begin
                if (!my_turn) begin
                    w_nxt_state = ST_IDLE;
                end else if (key_cancel) begin
                    // Cancel overrides any movement key in the same cycle.
                    w_nxt_state = ST_PIECE_SEL;
                    w_nxt_cur_x = r_src_x;
                    w_nxt_cur_y = r_src_y;
                end else begin
                    if (key_enter) begin
                        if (!w_cur_own) begin
                            w_nxt_state  = ST_VALIDATE;
                            w_nxt_req    = 1'b1;
                            w_nxt_timer  = '0;
                            // Destination is the judged square, even if a
                            // movement key shifts the cursor on this edge.
                            w_nxt_packet = {r_src_x, r_src_y, r_cur_x, r_cur_y};
                        end else if (w_on_src) begin
                            w_nxt_state = ST_PIECE_SEL;
                        end else begin
                            w_nxt_src_x = r_cur_x;
                            w_nxt_src_y = r_cur_y;
                            w_nxt_sel   = w_cur_piece;
                        end
                    end
                    w_nxt_cur_x = w_mv_x;
                    w_nxt_cur_y = w_mv_y;
                end
            end

            ST_VALIDATE: begin
                if (val_ack) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_req    = 1'b0;
                    w_nxt_done   = val_ok;
                    w_nxt_reject = !val_ok;
                end else if (r_timer == TW'(VAL_TIMEOUT - 1)) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_req    = 1'b0;
                    w_nxt_reject = 1'b1;
                end else begin
                    w_nxt_timer = r_timer + TW'(1);
                end
            end

            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_req   = 1'b0;
            end
        endcase

        // While selecting, the packet tracks the live selection; it is held
        // through VALIDATE and IDLE so the network path can sample it on the
        // move_done pulse.
        if (w_nxt_state == ST_PIECE_SEL || w_nxt_state == ST_DEST_SEL)
            w_nxt_packet = {w_nxt_src_x, w_nxt_src_y, w_nxt_cur_x, w_nxt_cur_y};
    end

    // ------------------------------------------------------------------
    // Display overlay for the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        w_nsq_cur  = int'(w_nxt_cur_y) * COLS + int'(w_nxt_cur_x);
        w_nsq_src  = int'(w_nxt_src_y) * COLS + int'(w_nxt_src_x);
        w_nxt_disp = board_in;
        w_nxt_hl   = '0;
        if (w_nxt_state != ST_IDLE)
            w_nxt_hl[w_nsq_cur] = 1'b1;
        if (w_nxt_state == ST_DEST_SEL || w_nxt_state == ST_VALIDATE) begin
            // Cursor write comes second so it wins when cursor == src.
            w_nxt_disp[w_nsq_src*PW +: PW] = PW'(EMPTY);
            w_nxt_disp[w_nsq_cur*PW +: PW] = w_nxt_sel;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cur_x   <= XW'(CX);
            r_cur_y   <= YW'(CY);
            r_src_x   <= XW'(CX);
            r_src_y   <= YW'(CY);
            r_sel     <= PW'(EMPTY);
            r_timer   <= '0;
            r_val_req <= 1'b0;
            r_done    <= 1'b0;
            r_reject  <= 1'b0;
            r_packet  <= '0;
            r_disp    <= {NSQ{PW'(EMPTY)}};
            r_hl      <= '0;
        end else if (enable) begin
            r_state   <= w_nxt_state;
            r_cur_x   <= w_nxt_cur_x;
            r_cur_y   <= w_nxt_cur_y;
            r_src_x   <= w_nxt_src_x;
            r_src_y   <= w_nxt_src_y;
            r_sel     <= w_nxt_sel;
            r_timer   <= w_nxt_timer;
            r_val_req <= w_nxt_req;
            r_done    <= w_nxt_done;
            r_reject  <= w_nxt_reject;
            r_packet  <= w_nxt_packet;
            r_disp    <= w_nxt_disp;
            r_hl      <= w_nxt_hl;
        end else begin
            // Frozen screen: everything holds except the result pulses.
            r_done   <= 1'b0;
            r_reject <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign state       = r_state;
    assign cur_x       = r_cur_x;
    assign cur_y       = r_cur_y;
    assign src_x       = r_src_x;
    assign src_y       = r_src_y;
    assign sel_piece   = r_sel;
    assign val_req     = r_val_req;
    assign move_done   = r_done;
    assign move_reject = r_reject;
    assign move_packet = r_packet;
    assign disp_board  = r_disp;
    assign highlight   = r_hl;

endmodule

// File: tb/tb_move_select_ctrl.sv
// Testbench for move_select_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the move-entry rules.
module tb_move_select_ctrl;

    localparam int COLS = 8, ROWS = 8, PW = 4, EMPTY = 15, WHITE_MAX = 5;
    localparam int VAL_TIMEOUT = 32;
    localparam int XW = $clog2(COLS), YW = $clog2(ROWS);
    localparam int NSQ = COLS * ROWS, BW = NSQ * PW, PKW = 2 * (XW + YW);
    localparam int CX = COLS / 2 - 1, CY = ROWS / 2 - 1;

    // Small 5x3 instance for the non-power-of-two edge case.
    localparam int C5 = 5, R5 = 3;
    localparam int XW5 = $clog2(C5), YW5 = $clog2(R5), NSQ5 = C5 * R5;

    logic clk, rst_n;
    logic enable, my_turn, player, dir, key_dec, key_inc, key_enter, key_cancel;
    logic [BW-1:0] board_in;
    logic val_req, val_ack, val_ok;
    logic [BW-1:0] disp_board;
    logic [NSQ-1:0] highlight;
    logic [XW-1:0] cur_x, src_x;
    logic [YW-1:0] cur_y, src_y;
    logic [PW-1:0] sel_piece;
    logic move_done, move_reject;
    logic [PKW-1:0] move_packet;
    logic [2:0] state;

    logic d5_en, d5_turn, d5_dec, d5_req;
    logic [NSQ5*PW-1:0] d5_board, d5_disp;
    logic [NSQ5-1:0] d5_hl;
    logic [XW5-1:0] d5_cx, d5_sx;
    logic [YW5-1:0] d5_cy, d5_sy;
    logic [PW-1:0] d5_sel;
    logic d5_done, d5_rej;
    logic [2*(XW5+YW5)-1:0] d5_pkt;
    logic [2:0] d5_state;

    int n_cmp, n_fail;
    bit chk_on;

    move_select_ctrl #(.COLS(COLS), .ROWS(ROWS), .PW(PW), .EMPTY(EMPTY),
                       .WHITE_MAX(WHITE_MAX), .VAL_TIMEOUT(VAL_TIMEOUT)) dut (
        .clk(clk), .reset_n(rst_n), .enable(enable), .my_turn(my_turn),
        .player(player), .dir(dir), .key_dec(key_dec), .key_inc(key_inc),
        .key_enter(key_enter), .key_cancel(key_cancel), .board_in(board_in),
        .val_req(val_req), .val_ack(val_ack), .val_ok(val_ok),
        .disp_board(disp_board), .highlight(highlight), .cur_x(cur_x),
        .cur_y(cur_y), .src_x(src_x), .src_y(src_y), .sel_piece(sel_piece),
        .move_done(move_done), .move_reject(move_reject),
        .move_packet(move_packet), .state(state)
    );

    move_select_ctrl #(.COLS(C5), .ROWS(R5), .PW(PW), .EMPTY(EMPTY),
                       .WHITE_MAX(WHITE_MAX), .VAL_TIMEOUT(VAL_TIMEOUT)) dut5 (
        .clk(clk), .reset_n(rst_n), .enable(d5_en), .my_turn(d5_turn),
        .player(1'b0), .dir(1'b0), .key_dec(d5_dec), .key_inc(1'b0),
        .key_enter(1'b0), .key_cancel(1'b0), .board_in(d5_board),
        .val_req(d5_req), .val_ack(1'b0), .val_ok(1'b0),
        .disp_board(d5_disp), .highlight(d5_hl), .cur_x(d5_cx),
        .cur_y(d5_cy), .src_x(d5_sx), .src_y(d5_sy), .sel_piece(d5_sel),
        .move_done(d5_done), .move_reject(d5_rej),
        .move_packet(d5_pkt), .state(d5_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Phases: 0 idle, 1 choosing a piece, 2 choosing a
    // destination, 3 awaiting the validator.
    // ------------------------------------------------------------------
    int m_state, m_x, m_y, m_sx, m_sy, m_sel, m_wait;
    bit m_req, m_done, m_rej;
    int m_pkt[4];
    logic [BW-1:0] m_disp;
    logic [NSQ-1:0] m_hl;

    function automatic int piece(input int x, input int y);
        return int'(board_in[(y*COLS+x)*PW +: PW]);
    endfunction

    function automatic bit own(input int p);
        return (p != EMPTY) && ((p <= WHITE_MAX) == (player == 1'b1));
    endfunction

    function automatic int mv(input int v, input int d, input int n);
`ifdef CURSOR_WRAP_EN
        return (v + d + n) % n;
`else
        return (v + d < 0) ? 0 : ((v + d > n - 1) ? n - 1 : v + d);
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = CX; m_y = CY; m_sx = CX; m_sy = CY;
        m_sel = EMPTY; m_wait = 0; m_req = 0; m_done = 0; m_rej = 0;
        m_pkt = '{0, 0, 0, 0};
        for (int i = 0; i < NSQ; i++) m_disp[i*PW +: PW] = PW'(EMPTY);
        m_hl = '0;
    endtask

    task automatic model_render();
        m_disp = board_in;
        m_hl = '0;
        if (m_state != 0) m_hl[m_y*COLS+m_x] = 1'b1;
        if (m_state >= 2) begin
            m_disp[(m_sy*COLS+m_sx)*PW +: PW] = PW'(EMPTY);
            m_disp[(m_y*COLS+m_x)*PW +: PW] = PW'(m_sel);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int p, nx, ny;
        if (!rst_n) begin
            model_reset();
        end else if (!enable) begin
            m_done = 0;
            m_rej = 0;
        end else begin
            m_done = 0;
            m_rej = 0;
            p = piece(m_x, m_y);
            nx = m_x;
            ny = m_y;
            if (key_dec) begin
                if (dir) ny = mv(m_y, -1, ROWS); else nx = mv(m_x, 1, COLS);
            end else if (key_inc) begin
                if (dir) ny = mv(m_y, 1, ROWS); else nx = mv(m_x, -1, COLS);
            end
            case (m_state)
                0: if (my_turn) begin m_state = 1; m_x = CX; m_y = CY; end
                1: if (!my_turn) m_state = 0;
                   else begin
                       if (key_enter && own(p)) begin
                           m_sx = m_x; m_sy = m_y; m_sel = p; m_state = 2;
                       end
                       m_x = nx; m_y = ny;
                   end
                2: if (!my_turn) m_state = 0;
                   else if (key_cancel) begin m_state = 1; m_x = m_sx; m_y = m_sy; end
                   else begin
                       if (key_enter) begin
                           if (!own(p)) begin
                               m_state = 3; m_req = 1; m_wait = 0;
                               m_pkt = '{m_sx, m_sy, m_x, m_y};
                           end else if (m_x == m_sx && m_y == m_sy) m_state = 1;
                           else begin m_sx = m_x; m_sy = m_y; m_sel = p; end
                       end
                       m_x = nx; m_y = ny;
                   end
                default: begin
                    if (val_ack) begin
                        m_req = 0; m_state = 0;
                        if (val_ok) m_done = 1; else m_rej = 1;
                    end else begin
                        m_wait++;
                        if (m_wait == VAL_TIMEOUT) begin m_req = 0; m_rej = 1; m_state = 0; end
                    end
                end
            endcase
            if (m_state == 1 || m_state == 2) m_pkt = '{m_sx, m_sy, m_x, m_y};
            model_render();
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_state", 512'(state), 512'(m_state));
            check("cmp_cur_x", 512'(cur_x), 512'(m_x));
            check("cmp_cur_y", 512'(cur_y), 512'(m_y));
            check("cmp_src_x", 512'(src_x), 512'(m_sx));
            check("cmp_src_y", 512'(src_y), 512'(m_sy));
            check("cmp_sel", 512'(sel_piece), 512'(m_sel));
            check("cmp_val_req", 512'(val_req), 512'(m_req));
            check("cmp_done", 512'(move_done), 512'(m_done));
            check("cmp_reject", 512'(move_reject), 512'(m_rej));
            check("cmp_packet", 512'(move_packet),
                  512'({XW'(m_pkt[0]), YW'(m_pkt[1]), XW'(m_pkt[2]), YW'(m_pkt[3])}));
            check("cmp_disp", 512'(disp_board), 512'(m_disp));
            check("cmp_hl", 512'(highlight), 512'(m_hl));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input bit dec, input bit inc, input bit ent, input bit can);
        key_dec = dec; key_inc = inc; key_enter = ent; key_cancel = can;
        idle();
        key_dec = 0; key_inc = 0; key_enter = 0; key_cancel = 0;
    endtask

    task automatic set_sq(input int x, input int y, input int code);
        board_in[(y*COLS+x)*PW +: PW] = PW'(code);
    endtask

    function automatic int disp_at(input int x, input int y);
        return int'(disp_board[(y*COLS+x)*PW +: PW]);
    endfunction

    initial begin
        int n;
        n_cmp = 0; n_fail = 0; chk_on = 0;
        rst_n = 1; enable = 0; my_turn = 0; player = 0; dir = 0;
        key_dec = 0; key_inc = 0; key_enter = 0; key_cancel = 0;
        val_ack = 0; val_ok = 0;
        d5_en = 0; d5_turn = 0; d5_dec = 0;
        for (int i = 0; i < NSQ; i++) set_sq(i % COLS, i / COLS, EMPTY);
        set_sq(1, 3, 8);   // own for player 0
        set_sq(2, 6, 9);   // own for player 0
        set_sq(3, 3, 2);   // enemy for player 0
        for (int i = 0; i < NSQ5; i++) d5_board[i*PW +: PW] = PW'(EMPTY);

        #2 rst_n = 0;
        chk_on = 1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;

        // Reset values
        check("rst_state", 512'(state), 512'(0));
        check("rst_cur", 512'({cur_x, cur_y}), 512'({3'd3, 3'd3}));
        check("rst_sel", 512'(sel_piece), 512'(15));
        check("rst_disp_all_empty", 512'(disp_board), {256'd0, {64{4'hF}}});

        // Non-power-of-two width: cursor at x=4 of 5 columns, step right.
        d5_en = 1; d5_turn = 1;
        idle();
        check("c5_state", 512'(d5_state), 512'(1));
        check("c5_centre_x", 512'(d5_cx), 512'(1));
        repeat (3) begin d5_dec = 1; idle(); d5_dec = 0; end
        check("c5_x_at_edge", 512'(d5_cx), 512'(4));
        d5_dec = 1; idle(); d5_dec = 0;
`ifdef CURSOR_WRAP_EN
        check("c5_x_past_edge", 512'(d5_cx), 512'(0));
`else
        check("c5_x_past_edge", 512'(d5_cx), 512'(4));
`endif

        // Enter the screen on our turn
        enable = 1; my_turn = 1;
        idle();
        check("t1_state", 512'(state), 512'(1));
        check("t1_cur", 512'({cur_x, cur_y}), 512'({3'd3, 3'd3}));
        check("t1_hl", 512'(highlight), 512'(64'd1 << 27));
        check("t1_quiet", 512'({val_req, move_done, move_reject}), 512'(0));

        // Enter on enemy square is ignored
        press(0, 0, 1, 0);
        check("enemy_enter_state", 512'(state), 512'(1));

        // Select (1,3) then destination (1,5), validator accepts
        dir = 0; press(0, 1, 0, 0); press(0, 1, 0, 0);
        check("nav_x", 512'(cur_x), 512'(1));
        press(0, 0, 1, 0);
        check("sel_state", 512'(state), 512'(2));
        check("sel_piece", 512'(sel_piece), 512'(8));
        check("sel_src", 512'({src_x, src_y}), 512'({3'd1, 3'd3}));
        check("sel_disp_src_cursor_wins", 512'(disp_at(1, 3)), 512'(8));
        dir = 1; press(0, 1, 0, 0);
        check("dest_disp_src_empty", 512'(disp_at(1, 3)), 512'(15));
        check("dest_disp_cursor", 512'(disp_at(1, 4)), 512'(8));
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        check("val_state", 512'(state), 512'(3));
        check("val_req_high", 512'(val_req), 512'(1));
        check("val_packet", 512'(move_packet), 512'({3'd1, 3'd3, 3'd1, 3'd5}));
        press(1, 0, 0, 0);
        check("val_cursor_frozen", 512'(cur_y), 512'(5));
        idle(); idle();
        val_ack = 1; val_ok = 1; idle(); val_ack = 0; val_ok = 0;
        check("ack_done", 512'(move_done), 512'(1));
        check("ack_state", 512'(state), 512'(0));
        check("ack_req_low", 512'(val_req), 512'(0));
        idle();
        check("ack_done_pulse", 512'(move_done), 512'(0));
        check("ack_next_cur", 512'({state, cur_x, cur_y}), 512'({3'd1, 3'd3, 3'd3}));

        // Same move, validator silent -> timeout reject
        dir = 0; press(0, 1, 0, 0); press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        dir = 1; press(0, 1, 0, 0); press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        check("to_req_rose", 512'(val_req), 512'(1));
        n = 0;
        while (move_reject !== 1'b1 && n < 100) begin
            idle();
            n++;
        end
        check("to_latency", 512'(n), 512'(VAL_TIMEOUT));
        check("to_req_drop", 512'(val_req), 512'(0));
        check("to_state", 512'(state), 512'(0));
        idle();
        check("to_reject_pulse", 512'(move_reject), 512'(0));

        // Re-select to own 9 at (2,6), then cancel
        dir = 0; press(0, 1, 0, 0); press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        dir = 1; press(0, 1, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        check("resel_state", 512'(state), 512'(2));
        check("resel_src", 512'({src_x, src_y}), 512'({3'd2, 3'd6}));
        check("resel_piece", 512'(sel_piece), 512'(9));
        press(0, 0, 0, 1);
        check("cancel_state", 512'(state), 512'(1));
        check("cancel_cur", 512'({cur_x, cur_y}), 512'({3'd2, 3'd6}));

        // Turn lost -> IDLE, no pulses
        my_turn = 0; idle();
        check("abort_state", 512'(state), 512'(0));
        check("abort_quiet", 512'({move_done, move_reject}), 512'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                #1 check("async_rst_req", 512'(val_req), 512'(0));
                @(negedge clk);
                #1 rst_n = 1;
            end else begin
                if ($urandom_range(0, 199) == 0) begin
                    for (int s = 0; s < NSQ; s++)
                        set_sq(s % COLS, s / COLS,
                               ($urandom_range(0, 1) == 0) ? EMPTY : int'($urandom_range(0, 14)));
                    player = 1'($urandom_range(0, 1));
                end
                enable = ($urandom_range(0, 9) != 0);
                my_turn = ($urandom_range(0, 39) != 0);
                dir = 1'($urandom_range(0, 1));
                key_dec = ($urandom_range(0, 99) < 15);
                key_inc = ($urandom_range(0, 99) < 15);
                key_enter = ($urandom_range(0, 99) < 15);
                key_cancel = ($urandom_range(0, 99) < 4);
                val_ack = ($urandom_range(0, 99) < 4);
                val_ok = 1'($urandom_range(0, 1));
                idle();
            end
        end
        key_dec = 0; key_inc = 0; key_enter = 0; key_cancel = 0;
        val_ack = 0; val_ok = 0;
        idle(); idle();
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
